// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch unit: holds the PC, fetches 64-bit aligned words from instruction
// memory and hands the selected 32-bit instruction to decode; redirects flush in-flight work.
//
// state | meaning
// REQ   | issue a read for pc (or fault if pc is misaligned)
// WAIT  | one read outstanding; drop marks a response that belongs to a stale pc
// HOLD  | instruction presented to decode until accepted
// FAULT | sticky fetch fault; only an aligned redirect leaves
module ysyx_220053_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [63:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic [31:0] instr_o,
    output logic [63:0] pc_o,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        fault_o
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t      state, state_nx;
    logic [63:0] pc, pc_nx;
    logic [63:0] pc_o_nx;
    logic [31:0] instr_nx;
    logic        drop, drop_nx;
    logic        instr_valid_nx;
    logic        fault_nx;
    logic        pc_aligned;

    assign pc_aligned     = (pc[1:0] == 2'b00);
    assign imem_req_addr  = {pc[63:3], 3'b000};
    assign imem_req_valid = !rst && (state == S_REQ) && !redirect_valid && pc_aligned;

    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        drop_nx        = drop;
        instr_nx       = instr_o;
        pc_o_nx        = pc_o;
        instr_valid_nx = instr_valid;
        fault_nx       = fault_o;

        case (state)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_nx = redirect_pc;
                end else if (!pc_aligned) begin
                    state_nx = S_FAULT;
                    fault_nx = 1'b1;
                end else if (imem_req_ready) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response landing with a redirect belongs to the old pc and is discarded.
                if (redirect_valid) begin
                    pc_nx = redirect_pc;
                    if (imem_resp_valid) begin
                        drop_nx  = 1'b0;
                        state_nx = S_REQ;
                    end else begin
                        drop_nx = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (drop) begin
                        drop_nx  = 1'b0;
                        state_nx = S_REQ;
                    end else if (imem_resp_err) begin
                        fault_nx = 1'b1;
                        state_nx = S_FAULT;
                    end else begin
                        instr_nx       = pc[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
                        pc_o_nx        = pc;
                        instr_valid_nx = 1'b1;
                        state_nx       = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid || instr_ready) begin
                    pc_nx          = redirect_valid ? redirect_pc : pc + 64'd4;
                    instr_valid_nx = 1'b0;
                    state_nx       = S_REQ;
                end
            end
            S_FAULT: begin
                if (redirect_valid && (redirect_pc[1:0] == 2'b00)) begin
                    pc_nx    = redirect_pc;
                    fault_nx = 1'b0;
                    state_nx = S_REQ;
                end
            end
            default: state_nx = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            instr_o     <= 32'd0;
            pc_o        <= 64'd0;
            instr_valid <= 1'b0;
            fault_o     <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            drop        <= drop_nx;
            instr_o     <= instr_nx;
            pc_o        <= pc_o_nx;
            instr_valid <= instr_valid_nx;
            fault_o     <= fault_nx;
        end
    end

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// Directed bench for the fetch unit: an in-bench memory model answers requests after a
// chosen latency; every step checks outputs against hand-computed values.
module tb_ysyx_220053_ifu;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [63:0] imem_resp_data;
    logic        imem_resp_err;
    logic [31:0] instr_o;
    logic [63:0] pc_o;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fault_o;

    int          total;
    int          bad;
    int          lat;
    int          cnt;
    logic        pend;
    logic [63:0] paddr;
    logic [63:0] err_addr;

    ysyx_220053_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .fault_o         (fault_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] exp_instr(input logic [63:0] p);
        if (p == 64'h8000_0000) return 32'h0000_0013;
        if (p == 64'h8000_0004) return 32'h0010_0093;
        return p[31:0] ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [63:0] mem_data(input logic [63:0] a);
        return {exp_instr(a + 64'd4), exp_instr(a)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; acceptance is sampled mid-cycle, memory outputs change just after the edge.
    task automatic tick();
        logic        acc;
        logic [63:0] aaddr;
        @(negedge clk);
        acc   = imem_req_valid && imem_req_ready;
        aaddr = imem_req_addr;
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        imem_resp_err   = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (acc) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = aaddr;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_data(paddr);
                    imem_resp_err   = (paddr == err_addr);
                    pend            = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (instr_valid === 1'b1) break;
            tick();
        end
        chk(tag, {63'd0, instr_valid}, 64'd1);
    endtask

    task automatic handoff();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        #1;
    endtask

    task automatic redirect(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
        #1;
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        lat             = 1;
        cnt             = 0;
        pend            = 1'b0;
        paddr           = 64'd0;
        err_addr        = '1;
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 64'd0;
        imem_resp_err   = 1'b0;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 64'd0;

        // reset
        tick();
        tick();
        chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_fault", {63'd0, fault_o}, 64'd0);
        chk("rst_instr_o", {32'd0, instr_o}, 64'd0);
        chk("rst_pc_o", pc_o, 64'd0);
        chk("rst_addr", imem_req_addr, 64'h8000_0000);
        rst = 1'b0;
        #1;
        chk("post_rst_req_valid", {63'd0, imem_req_valid}, 64'd1);

        // basic fetch of both halves
        imem_req_ready = 1'b1;
        lat = 1;
        wait_valid("t1_valid0");
        chk("t1_instr0", {32'd0, instr_o}, 64'h0000_0013);
        chk("t1_pc0", pc_o, 64'h8000_0000);
        handoff();
        wait_valid("t1_valid1");
        chk("t1_instr1", {32'd0, instr_o}, 64'h0010_0093);
        chk("t1_pc1", pc_o, 64'h8000_0004);

        // backpressure in HOLD
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_valid", {63'd0, instr_valid}, 64'd1);
            chk("t2_hold_instr", {32'd0, instr_o}, 64'h0010_0093);
            chk("t2_hold_pc", pc_o, 64'h8000_0004);
            chk("t2_no_req", {63'd0, imem_req_valid}, 64'd0);
        end
        handoff();
        chk("t2_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("t2_next_addr", imem_req_addr, 64'h8000_0008);
        wait_valid("t2_valid");
        chk("t2_pc", pc_o, 64'h8000_0008);
        chk("t2_instr", {32'd0, instr_o}, 64'h25A5_0008);

        // redirect coinciding with handoff
        instr_ready = 1'b1;
        redirect(64'h8000_0040);
        instr_ready = 1'b0;
        #1;
        chk("t6_valid_drop", {63'd0, instr_valid}, 64'd0);
        chk("t6_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("t6_addr", imem_req_addr, 64'h8000_0040);
        wait_valid("t6_valid");
        chk("t6_pc", pc_o, 64'h8000_0040);
        chk("t6_instr", {32'd0, instr_o}, 64'h25A5_0040);
        handoff();

        // redirect in WAIT, stale response two cycles later
        lat = 3;
        tick();
        chk("t3_wait_no_req", {63'd0, imem_req_valid}, 64'd0);
        redirect(64'h8000_0100);
        tick();
        chk("t3_valid_a", {63'd0, instr_valid}, 64'd0);
        lat = 1;
        tick();
        chk("t3_valid_b", {63'd0, instr_valid}, 64'd0);
        chk("t3_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("t3_addr", imem_req_addr, 64'h8000_0100);
        wait_valid("t3_valid");
        chk("t3_pc", pc_o, 64'h8000_0100);
        chk("t3_instr", {32'd0, instr_o}, 64'h25A5_0100);
        handoff();

        // redirect and response in the same WAIT cycle
        tick();
        redirect(64'h8000_0204);
        chk("t4_valid", {63'd0, instr_valid}, 64'd0);
        chk("t4_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("t4_addr", imem_req_addr, 64'h8000_0200);
        wait_valid("t4_valid_out");
        chk("t4_pc", pc_o, 64'h8000_0204);
        chk("t4_instr", {32'd0, instr_o}, 64'h25A5_0204);
        handoff();

        // access fault, misaligned recovery attempt, aligned recovery
        err_addr = 64'h8000_0208;
        tick();
        tick();
        chk("t5_fault", {63'd0, fault_o}, 64'd1);
        chk("t5_valid", {63'd0, instr_valid}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_req", {63'd0, imem_req_valid}, 64'd0);
        end
        redirect(64'h8000_0002);
        chk("t5_still_fault", {63'd0, fault_o}, 64'd1);
        chk("t5_still_no_req", {63'd0, imem_req_valid}, 64'd0);
        redirect(64'h8000_0010);
        err_addr = '1;
        chk("t5_cleared", {63'd0, fault_o}, 64'd0);
        chk("t5_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("t5_addr", imem_req_addr, 64'h8000_0010);
        wait_valid("t5_valid_out");
        chk("t5_pc", pc_o, 64'h8000_0010);
        chk("t5_instr", {32'd0, instr_o}, 64'h25A5_0010);
        handoff();

        // misaligned redirect while in REQ
        redirect(64'h8000_0006);
        chk("t7_no_req", {63'd0, imem_req_valid}, 64'd0);
        chk("t7_no_fault_yet", {63'd0, fault_o}, 64'd0);
        tick();
        chk("t7_fault", {63'd0, fault_o}, 64'd1);

        // reset mid-operation
        rst = 1'b1;
        tick();
        chk("t8_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("t8_fault", {63'd0, fault_o}, 64'd0);
        chk("t8_instr_o", {32'd0, instr_o}, 64'd0);
        chk("t8_pc_o", pc_o, 64'd0);
        rst = 1'b0;
        #1;
        chk("t8_req_valid_after", {63'd0, imem_req_valid}, 64'd1);
        chk("t8_addr", imem_req_addr, 64'h8000_0000);

        // pc + 4 wraps at the top of the address space
        redirect(64'hFFFF_FFFF_FFFF_FFFC);
        wait_valid("t9_valid");
        chk("t9_pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t9_instr", {32'd0, instr_o}, 64'h5A5A_FFFC);
        handoff();
        chk("t9_wrap_addr", imem_req_addr, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_220053_ifu.md
Name: ysyx_220053_ifu

Overview:
Instruction fetch unit. Holds the PC and issues 64-bit-aligned reads to instruction memory over a valid/ready request and valid response channel. It extracts the 32-bit instruction word and presents it, with its PC, to the decode stage over a valid/ready handshake. Taken branches, jumps and traps arrive as a redirect, which flushes any in-flight or held fetch.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
imem_req_valid  output  1  read request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  64  {pc[63:3],3'b000}
imem_resp_valid  input  1  read data valid (exactly one response per accepted request, ≥1 cycle after acceptance)
imem_resp_data  input  64  read data
imem_resp_err  input  1  access fault, qualified by imem_resp_valid
instr_o  output  32  instruction to decoder
pc_o  output  64  PC of instr_o
instr_valid  output  1  instr_o/pc_o valid
instr_ready  input  1  decoder accepts
redirect_valid  input  1  redirect request
redirect_pc  input  64  redirect target
fault_o  output  1  sticky fetch fault

Behaviour:
- Reset: pc=RESET_PC, state=REQ, drop=0, instr_o=0, pc_o=0, instr_valid=0, fault_o=0, imem_req_valid=0 during the reset cycle.
- States: REQ, WAIT, HOLD, FAULT. Redirect has priority over every other event in every state.
- REQ:
  - imem_req_valid = !redirect_valid && pc[1:0]==0.
  - pc[1:0]!=0 -> FAULT next cycle, no request issued.
  - Request valid and imem_req_ready -> WAIT.
  - redirect_valid -> pc<=redirect_pc, stay REQ.
- WAIT:
  - imem_resp_valid and drop=1 -> discard response, drop<=0, -> REQ.
  - imem_resp_valid, drop=0, imem_resp_err=1 -> FAULT.
  - imem_resp_valid, drop=0, no error -> instr_o <= pc[2] ? data[63:32] : data[31:0]; pc_o<=pc; -> HOLD.
  - redirect_valid -> pc<=redirect_pc, drop<=1, stay WAIT; a response arriving in the same cycle is the old fetch and is discarded (drop stays 1 only if no response in that cycle; otherwise -> REQ with drop=0).
  - A second redirect while drop=1 only updates pc.
- HOLD:
  - instr_valid=1; instr_o/pc_o stable until handoff.
  - instr_valid && instr_ready -> pc<=pc+4 (64-bit wrap), -> REQ.
  - redirect_valid -> pc<=redirect_pc, instr_valid drops next cycle, -> REQ. If the handoff occurs in the same cycle, the instruction counts as consumed but pc takes redirect_pc.
- FAULT:
  - fault_o=1, no requests, instr_valid=0.
  - redirect_valid with redirect_pc[1:0]==0 -> fault_o<=0, pc<=redirect_pc, -> REQ.
  - Misaligned redirect leaves the block in FAULT.
- instr_valid, instr_o, pc_o and fault_o are registered outputs. imem_req_valid is combinational from state, pc and redirect_valid.
- At most one outstanding request. Peak throughput is one instruction per 3 cycles with single-cycle memory (REQ, WAIT, HOLD).
- rst asserted mid-operation returns everything to reset values next edge. A response to a pre-reset request is not expected; memory is reset with the same rst.

Test Plan:
1. Reset, memory returns 64'h00100093_00000013 one cycle after acceptance, instr_ready=1 -> instr_o=32'h00000013, pc_o=8000_0000; then instr_o=32'h00100093, pc_o=8000_0004; next imem_req_addr=8000_0008.
2. Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr_valid held at 1, instr_o/pc_o unchanged, no new imem_req_valid. Releasing ready -> pc advances by exactly 4.
3. Redirect in WAIT to 8000_0100, old response arrives 2 cycles later -> response discarded, instr_valid stays 0, next imem_req_addr=8000_0100, delivered pc_o=8000_0100.
4. Redirect and resp_valid in same WAIT cycle (target 8000_0204) -> response dropped, next request addr 8000_0200, delivered instr from upper half, pc_o=8000_0204.
5. imem_resp_err=1 -> fault_o=1, no requests. Redirect to 8000_0002 -> still FAULT. Redirect to 8000_0010 -> fault_o=0, fetch resumes at 8000_0010.
6. Redirect coinciding with handoff in HOLD (pc 8000_0008, target 8000_0040) -> one instruction accepted, next pc_o=8000_0040, never 8000_000C.
